// File: rtl/fifo_threshold_buf.sv
// Per-lane synchronous FIFO with programmable almost-full/almost-empty thresholds.
// Optional macro FIFO_PASSTHRU_EN: push+pop on an empty FIFO bypasses memory.
module fifo_threshold_buf #(
  parameter int unsigned DATA_WIDTH = 6,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   th_almost_full,
  input  logic [ADDR_WIDTH:0]   th_almost_empty,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  fifo_error,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] TH_AF_RST = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] TH_AE_RST = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    ST_CONFIG = 2'd0,
    ST_RUN    = 2'd1,
    ST_ERROR  = 2'd2
  } state_e;

  state_e                  state_q,  state_d;
  logic [ADDR_WIDTH:0]     th_af_q,  th_af_d;
  logic [ADDR_WIDTH:0]     th_ae_q,  th_ae_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     count_q,  count_d;
  logic [DATA_WIDTH-1:0]   dout_q,   dout_d;
  logic                    valid_q,  valid_d;
  logic                    error_q,  error_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    mem_we;
  logic                    is_full;
  logic                    is_empty;
  logic                    push_ok;
  logic                    pop_ok;
  logic                    passthru;

  assign is_full  = (count_q == DEPTH_C);
  assign is_empty = (count_q == '0);
  assign rd_data  = mem[rd_ptr_q];

`ifdef FIFO_PASSTHRU_EN
  assign passthru = push && pop && is_empty;
`else
  assign passthru = 1'b0;
`endif

  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign push_ok = push && (!is_full || pop) && !passthru;
  assign pop_ok  = pop && !is_empty;

  always_comb begin
    state_d  = state_q;
    th_af_d  = th_af_q;
    th_ae_d  = th_ae_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = 1'b0;
    error_d  = error_q;
    mem_we   = 1'b0;

    case (state_q)
      ST_CONFIG: begin
        th_af_d  = (th_almost_full  > DEPTH_C) ? DEPTH_C : th_almost_full;
        th_ae_d  = (th_almost_empty > DEPTH_C) ? DEPTH_C : th_almost_empty;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        error_d  = 1'b0;
        if (!init) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (init) begin
          state_d  = ST_CONFIG;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end else if (passthru) begin
          dout_d  = data_in;
          valid_d = 1'b1;
        end else begin
          if (push_ok) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
          end
          if (pop_ok) begin
            dout_d   = rd_data;
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
          end
          count_d = count_q + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
          // Underflow still commits a concurrent push before freezing.
          if ((push && is_full && !pop) || (pop && is_empty)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end

      ST_ERROR: begin
        if (init) begin
          state_d  = ST_CONFIG;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end
      end

      default: begin
        state_d = ST_CONFIG;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_CONFIG;
      th_af_q  <= TH_AF_RST;
      th_ae_q  <= TH_AE_RST;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      th_af_q  <= th_af_d;
      th_ae_q  <= th_ae_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= data_in;
  end

  assign data_out     = dout_q;
  assign valid_out    = valid_q;
  assign count        = count_q;
  assign fifo_error   = error_q;
  assign fifo_empty   = is_empty;
  assign fifo_full    = is_full;
  assign almost_full  = (th_af_q == '0) || (count_q >= th_af_q);
  assign almost_empty = (th_ae_q == DEPTH_C) || (count_q <= th_ae_q);

endmodule

// File: tb/tb_fifo_threshold_buf.sv
// Directed testbench for fifo_threshold_buf (DEPTH 8, 6-bit data).
module tb_fifo_threshold_buf;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [3:0] th_almost_full;
  logic [3:0] th_almost_empty;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_full;
  logic       almost_empty;
  logic       fifo_error;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  fifo_threshold_buf #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .th_almost_full (th_almost_full),
    .th_almost_empty(th_almost_empty),
    .push           (push),
    .data_in        (data_in),
    .pop            (pop),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .fifo_error     (fifo_error),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic [5:0] d, input logic q);
    push    = p;
    data_in = d;
    pop     = q;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; init = 1'b0; th_almost_full = 4'd6; th_almost_empty = 4'd2;
    drive(1'b0, 6'h00, 1'b0);
    #2;
    check("rst_data_out", data_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_count", count, 0);
    check("rst_error", fifo_error, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_af", almost_full, 0);
    check("rst_ae", almost_empty, 1);

    // configuration phase
    cycle();
    reset = 1'b0;
    init  = 1'b1;
    cycle(); cycle();
    init = 1'b0;
    cycle();
    check("cfg_empty", fifo_empty, 1);
    check("cfg_ae", almost_empty, 1);
    check("cfg_af", almost_full, 0);

    // fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'(i), 1'b0);
      cycle();
      check("fill_count", count, i);
      check("fill_af", almost_full, (i >= 6) ? 1 : 0);
      check("fill_ae", almost_empty, (i <= 2) ? 1 : 0);
      check("fill_full", fifo_full, (i == 8) ? 1 : 0);
    end

    // drain
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 6'h00, 1'b1);
      cycle();
      check("drain_data", data_out, i);
      check("drain_valid", valid_out, 1);
    end
    drive(1'b0, 6'h00, 1'b0);
    check("drain_empty", fifo_empty, 1);
    cycle();
    check("idle_valid", valid_out, 0);

    // full with simultaneous push/pop
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'(i), 1'b0);
      cycle();
    end
    drive(1'b1, 6'h2A, 1'b1);
    cycle();
    check("fpp_count", count, 8);
    check("fpp_error", fifo_error, 0);
    check("fpp_data", data_out, 1);
    check("fpp_valid", valid_out, 1);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 6'h00, 1'b1);
      cycle();
      check("fpp_drain", data_out, (i == 8) ? 32'h2A : 32'(i + 1));
    end
    drive(1'b0, 6'h00, 1'b0);
    check("fpp_empty", fifo_empty, 1);

    // overflow
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 6'(i), 1'b0);
      cycle();
    end
    drive(1'b1, 6'h3F, 1'b0);
    cycle();
    check("ovf_error", fifo_error, 1);
    check("ovf_count", count, 8);
    drive(1'b0, 6'h00, 1'b1);
    cycle();
    check("err_pop_valid", valid_out, 0);
    check("err_count", count, 8);
    check("err_sticky", fifo_error, 1);
    drive(1'b0, 6'h00, 1'b0);
    init = 1'b1;
    cycle();
    check("ovf_flush_count", count, 0);
    check("ovf_flush_error", fifo_error, 0);
    init = 1'b0;
    cycle();

    // underflow or passthrough on empty FIFO
    drive(1'b1, 6'h15, 1'b1);
    cycle();
`ifdef FIFO_PASSTHRU_EN
    check("pt_data", data_out, 32'h15);
    check("pt_valid", valid_out, 1);
    check("pt_count", count, 0);
    check("pt_error", fifo_error, 0);
`else
    check("udf_error", fifo_error, 1);
    check("udf_valid", valid_out, 0);
    check("udf_count", count, 1);
`endif
    drive(1'b0, 6'h00, 1'b0);
    init = 1'b1;
    cycle();
    init = 1'b0;
    cycle();
    check("udf_recover", count, 0);

    // wrap-around: preload 3, then 20 push+pop cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'(8'h10 + i), 1'b0);
      cycle();
    end
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 6'(8'h13 + j), 1'b1);
      cycle();
      check("wrap_data", data_out, 32'h10 + j);
    end
    check("wrap_count", count, 3);
    check("wrap_error", fifo_error, 0);

    // mid-burst asynchronous reset
    drive(1'b1, 6'h30, 1'b1);
    cycle();
    #2;
    reset = 1'b1;
    #1;
    check("mrst_data", data_out, 0);
    check("mrst_valid", valid_out, 0);
    check("mrst_count", count, 0);
    check("mrst_empty", fifo_empty, 1);
    check("mrst_af", almost_full, 0);
    check("mrst_ae", almost_empty, 1);
    #1;
    reset = 1'b0;
    drive(1'b1, 6'h05, 1'b0);
    cycle();
    check("post_rst_cfg_count", count, 0);
    cycle();
    check("post_rst_run_count", count, 1);
    drive(1'b0, 6'h00, 1'b1);
    cycle();
    check("post_rst_data", data_out, 32'h05);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_threshold_buf.md
# fifo_threshold_buf

- Per-lane synchronous FIFO that sits on the far side of the control FSM.
- While `init` is high it takes the almost-full/almost-empty thresholds the controller drives.
- It buffers lane data and reports `fifo_empty`, `almost_full`, `almost_empty` and `fifo_error` back to the controller.
- One instance per lane; the controller's 5-bit status vectors are built from five instances.

## Interface
- `DATA_WIDTH`, 6: payload width.
- `ADDR_WIDTH`, 3: pointer width; depth `DEPTH = 2**ADDR_WIDTH` (8).
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `init`  in  1  high = configuration phase (controller INIT state).
- `th_almost_full`  in  ADDR_WIDTH+1  almost-full threshold, sampled in CONFIG.
- `th_almost_empty`  in  ADDR_WIDTH+1  almost-empty threshold, sampled in CONFIG.
- `push`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  `data_out` valid this cycle.
- `fifo_empty`  out  1  count == 0.
- `fifo_full`  out  1  count == DEPTH.
- `almost_full`  out  1  count >= threshold_af.
- `almost_empty`  out  1  count <= threshold_ae.
- `fifo_error`  out  1  sticky overflow/underflow indication.
- `count`  out  ADDR_WIDTH+1  current occupancy.

## Operation
- **States:** CONFIG, RUN, ERROR. Reset enters CONFIG.
- **CONFIG**
  - Each cycle, threshold registers load the inputs, clamped to DEPTH if larger.
  - Pointers and count are held at 0; push and pop are ignored.
  - Exits to RUN on the first edge with `init` low.
- **RUN**
  - Push accepted if not full, or if full with a simultaneous pop. Memory is written at `wr_ptr`, which increments.
  - Pop accepted if not empty: `data_out` <= mem[`rd_ptr`], `valid_out` = 1 next cycle, `rd_ptr` increments.
  - Push+pop both accepted: count unchanged.
  - Pointers wrap modulo DEPTH naturally. Count is the only full/empty discriminator.
  - Push while full without pop is an overflow: data dropped, go to ERROR.
  - Pop while empty is an underflow: no `valid_out`, go to ERROR. This applies even with a simultaneous push, whose data is still written; see Configuration.
  - `init` high goes to CONFIG, taking priority over push/pop in that cycle.
- **ERROR**
  - `fifo_error` = 1; push and pop are ignored; contents are frozen.
  - `init` high goes to CONFIG, which flushes the FIFO and clears `fifo_error`. Only `init` or `reset` leave ERROR.
- **Flags:** combinational from registered count and thresholds.
  - Comparisons are unsigned, ADDR_WIDTH+1 bits.
  - threshold_af = 0 forces `almost_full` = 1.
  - threshold_ae = DEPTH forces `almost_empty` = 1.

## Timing
- **Reset values:**
  - `data_out` = 0, `valid_out` = 0, `count` = 0, `fifo_error` = 0.
  - `fifo_empty` = 1, `fifo_full` = 0, `almost_full` = 0, `almost_empty` = 1.
  - threshold_af = DEPTH-1, threshold_ae = 1, state = CONFIG.
- **Read latency:** 1 cycle. Pop at edge N gives `data_out`/`valid_out` during cycle N+1. `valid_out` is low in any cycle without an accepted pop.
- **Flag latency:** count and all flags reflect edge N's push/pop from just after edge N.
- **Error latency:** `fifo_error` rises the cycle after the offending edge.
- **Thresholds:** the values present on the last CONFIG edge are the ones used in RUN.
- **Reset mid-operation:** reset asserted at any time clears state asynchronously. Deassertion takes effect at the next edge, in CONFIG.

## Configuration
- `FIFO_PASSTHRU_EN` defined:
  - Push+pop on an empty FIFO in RUN passes `data_in` through to `data_out` with `valid_out` = 1 next cycle.
  - No memory write, no count change, no underflow.
- Undefined: the same event is an underflow as described in Operation.

## Test plan
- **Reset and config:** reset, then hold `init`=1 with th_af=6, th_ae=2, then drop it. Required: state RUN, `fifo_empty`=1, `almost_empty`=1, `almost_full`=0.
- **Fill and drain:** push 0x01..0x08. After the 6th push `almost_full`=1; after the 8th `fifo_full`=1, `count`=8. Then pop 8 times: `data_out` 0x01..0x08 each one cycle after its pop, ending with `fifo_empty`=1.
- **Overflow:** at full, push 0x3F alone. Required: next cycle `fifo_error`=1, `count`=8. Pulsing `init` gives `count`=0, `fifo_error`=0.
- **Full + simultaneous push/pop:** at full, push 0x2A and pop together. Required: `count` stays 8, no error, and 0x2A comes out as the 8th subsequent pop.
- **Underflow / passthrough:** empty FIFO, push 0x15 and pop together. Without `FIFO_PASSTHRU_EN`: `fifo_error`=1. With it: `data_out`=0x15, `valid_out`=1, `count`=0.
- **Wrap-around and mid-op reset:** run 20 interleaved push/pop cycles to wrap the pointers; data order must be preserved. Assert `reset` mid-burst: outputs take reset values before the next edge.
